// File: rtl/ram_fifo_ctrl.sv
// FIFO controller using a single-port 16x8 RAM as storage.
// Arbitrates writes vs read fetches; output register hides read latency.
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              fetch_q, fetch_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              prio_q, prio_d;

  logic not_full;
  logic wr_req, rd_req;
  logic gnt_wr, gnt_rd;

  assign not_full = (count_q != DEPTH_C);
  assign wr_req   = wr_valid & not_full;
  assign rd_req   = (count_q != '0) & ~fetch_q
                  & (~out_valid_q | rd_ready);

  // prio=0 favours writes, prio=1 favours reads
  assign gnt_wr = wr_req & (~rd_req | ~prio_q);
  assign gnt_rd = rd_req & (~wr_req | prio_q);

  assign wr_ready = not_full & (~rd_req | ~prio_q);
  assign rd_valid = out_valid_q;
  assign rd_data  = out_data_q;
  assign full     = ~not_full;
  assign level    = count_q;

  assign ram_cs   = gnt_wr | gnt_rd;
  assign ram_we   = gnt_wr;
  assign ram_addr = gnt_wr ? wr_ptr_q : rd_ptr_q;
  assign ram_din  = wr_data;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fetch_d     = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    prio_d      = prio_q;

    if (wr_req & rd_req)
      prio_d = ~prio_q;

    unique case (1'b1)
      gnt_wr: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      gnt_rd: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
        fetch_d  = 1'b1;
      end
      default: ;
    endcase

    // A landing fetch wins over a same-edge pop
    if (fetch_q) begin
      out_data_d  = ram_dout;
      out_valid_d = 1'b1;
    end else if (out_valid_q & rd_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fetch_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      prio_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fetch_q     <= fetch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      prio_q      <= prio_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural ram16x8 model.
// Scoreboard queue tracks accepted writes against popped words.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready = 1'b0;
  logic       full;
  logic [4:0] level;
  logic       ram_cs;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = 8'h00;

  logic [7:0] mem [16];
  logic [7:0] q [$];
  logic [7:0] sb_exp;
  int tests = 0;
  int fails = 0;
  int wr_acc = 0;
  int pops = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .full(full), .level(level),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  // Scoreboard monitor, mid-cycle: handshakes complete on the next edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid && wr_ready) begin
        q.push_back(wr_data);
        wr_acc++;
      end
      if (rd_valid && rd_ready) begin
        tests++;
        pops++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL pop_order: got %02h, expected nothing", rd_data);
        end else begin
          sb_exp = q.pop_front();
          if (rd_data !== sb_exp) begin
            fails++;
            $display("FAIL pop_order: got %02h, expected %02h",
                     rd_data, sb_exp);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    tests++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || full !== 1'b0 ||
        level !== 5'd0 || ram_cs !== 1'b0 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: rv=%b rd=%02h full=%b lvl=%0d cs=%b we=%b, expected all 0",
               rd_valid, rd_data, full, level, ram_cs, ram_we);
    end
    q.delete();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    wr_valid = 1'b1;
    wr_data = 8'hAA;
    #1;
    tests++;
    if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'd0) begin
      fails++;
      $display("FAIL lat_c1: cs=%b we=%b addr=%0d, expected 1 1 0",
               ram_cs, ram_we, ram_addr);
    end
    step();
    wr_data = 8'hBB;
    #1;
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 4'd1 || wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL lat_c2: we=%b addr=%0d wr_ready=%b, expected 1 1 1",
               ram_we, ram_addr, wr_ready);
    end
    step();
    wr_valid = 1'b0;
    #1;
    tests++;
    if (ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 4'd0) begin
      fails++;
      $display("FAIL lat_c3: cs=%b we=%b addr=%0d, expected 1 0 0",
               ram_cs, ram_we, ram_addr);
    end
    step();
    #1;
    tests++;
    if (rd_valid !== 1'b0 || level !== 5'd1 || ram_cs !== 1'b0) begin
      fails++;
      $display("FAIL lat_c4: rv=%b lvl=%0d cs=%b, expected 0 1 0",
               rd_valid, level, ram_cs);
    end
    step();
    #1;
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hAA || level !== 5'd1) begin
      fails++;
      $display("FAIL lat_c5: rv=%b rd=%02h lvl=%0d, expected 1 aa 1",
               rd_valid, rd_data, level);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    n = 0;
    while (!(q.size() == 0 && !rd_valid && level == 5'd0) && n < 100) begin
      step();
      n++;
    end
    tests++;
    if (n >= 100) begin
      fails++;
      $display("FAIL %s_drain: %0d words left, expected 0", nm, q.size());
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_full();
    int idx, bad;
    rd_ready = 1'b0;
    wr_acc = 0;
    idx = 0;
    bad = 0;
    wr_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      wr_data = 8'(idx);
      #1;
      if (full && ram_we) bad++;
      if (wr_ready && idx < 20) begin
        step();
        idx++;
      end else step();
      if (idx >= 20) wr_valid = 1'b0;
    end
    wr_data = 8'(idx);
    #1;
    tests++;
    if (wr_acc !== 17) begin
      fails++;
      $display("FAIL full_accepted: got %0d, expected 17", wr_acc);
    end
    tests++;
    if (full !== 1'b1 || level !== 5'd16 || wr_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_flags: full=%b lvl=%0d wr_ready=%b, expected 1 16 0",
               full, level, wr_ready);
    end
    tests++;
    if (bad !== 0 || rd_data !== 8'h00) begin
      fails++;
      $display("FAIL full_stall: we_while_full=%0d head=%02h, expected 0 00",
               bad, rd_data);
    end
    drain("full");
  endtask

  task automatic test_wrap();
    int idx, p0, n;
    p0 = pops;
    idx = 0;
    n = 0;
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    while (idx < 20 && n < 200) begin
      wr_data = 8'(idx);
      #1;
      if (wr_ready) idx++;
      step();
      n++;
    end
    drain("wrap");
    tests++;
    if (pops - p0 !== 20) begin
      fails++;
      $display("FAIL wrap_count: got %0d pops, expected 20", pops - p0);
    end
  endtask

  // After reset prio=0: W only, then W(cont) R(cont) W(fetch) repeating
  task automatic test_alternate();
    logic exp_we;
    int idx;
    test_reset();
    idx = 8'h40;
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      wr_data = 8'(idx);
      #1;
      exp_we = (k == 1) ? 1'b1 : ((k - 2) % 3 != 1);
      tests++;
      if (ram_cs !== 1'b1 || ram_we !== exp_we || wr_ready !== exp_we) begin
        fails++;
        $display("FAIL alt_c%0d: cs=%b we=%b wr_ready=%b, expected 1 %b %b",
                 k, ram_cs, ram_we, wr_ready, exp_we, exp_we);
      end
      if (wr_ready) idx++;
      step();
    end
    drain("alt");
  endtask

  task automatic fill3(input logic [7:0] base);
    int n;
    wr_acc = 0;
    n = 0;
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    while (wr_acc < 3 && n < 20) begin
      wr_data = base + 8'(wr_acc);
      step();
      n++;
    end
    wr_valid = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_midreset();
    int p0, n;
    fill3(8'h31);
    tests++;
    if (rd_valid !== 1'b1 || level !== 5'd2) begin
      fails++;
      $display("FAIL mrst_pre: rv=%b lvl=%0d, expected 1 2", rd_valid, level);
    end
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    tests++;
    if (rd_valid !== 1'b0 || level !== 5'd0 || ram_cs !== 1'b0) begin
      fails++;
      $display("FAIL mrst_hold: rv=%b lvl=%0d cs=%b, expected 0 0 0",
               rd_valid, level, ram_cs);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    fill3(8'h61);
    rd_ready = 1'b1;
    #1;
    tests++;
    if (ram_cs !== 1'b1 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL mrst_fetch: cs=%b we=%b, expected 1 0", ram_cs, ram_we);
    end
    step();
    rd_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    tests++;
    if (rd_valid !== 1'b0 || level !== 5'd0) begin
      fails++;
      $display("FAIL mrst_pend: rv=%b lvl=%0d, expected 0 0", rd_valid, level);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    rd_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      tests++;
      if (rd_valid !== 1'b0 || level !== 5'd0) begin
        fails++;
        $display("FAIL mrst_stale%0d: rv=%b rd=%02h lvl=%0d, expected 0 - 0",
                 c, rd_valid, rd_data, level);
      end
    end
    p0 = pops;
    wr_valid = 1'b1;
    wr_data = 8'h5A;
    step();
    wr_valid = 1'b0;
    n = 0;
    while (pops == p0 && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (pops - p0 !== 1) begin
      fails++;
      $display("FAIL mrst_new: got %0d pops, expected 1", pops - p0);
    end
  endtask

  task automatic test_idle();
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      tests++;
      if (ram_cs !== 1'b0 || rd_valid !== 1'b0 || level !== 5'd0) begin
        fails++;
        $display("FAIL idle%0d: cs=%b rv=%b lvl=%0d, expected 0 0 0",
                 c, ram_cs, rd_valid, level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    drain("lat");
    test_full();
    test_wrap();
    test_alternate();
    test_midreset();
    test_idle();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d words, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
FIFO controller that sits directly upstream of the ram16x8 single-port RAM and uses it as storage. It turns a valid/ready write stream and a valid/ready read stream into cs/we/addr/data_in accesses on the single RAM port. Because the port allows only one access per cycle, the block arbitrates between writes and read fetches. It absorbs the RAM's one-cycle synchronous read latency in a one-entry output register.

Parameters:
DATA_W, 8, data width; matches RAM data_in/data_out width
ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W = 16 (derived, not overridable)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  write request
wr_data  input  DATA_W  write data
wr_ready  output  1  write accepted this cycle when wr_valid & wr_ready
rd_valid  output  1  rd_data holds valid head-of-FIFO word
rd_data  output  DATA_W  output register contents
rd_ready  input  1  consumer pops when rd_valid & rd_ready
full  output  1  RAM occupancy == DEPTH
level  output  ADDR_W+1  RAM occupancy 0..DEPTH; excludes in-flight fetch and output register
ram_cs  output  1  RAM chip select
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM address
ram_din  output  DATA_W  RAM write data
ram_dout  input  DATA_W  RAM read data; valid the cycle after a read access

Behaviour:
- State:
  - wr_ptr, rd_ptr: ADDR_W bits, wrap naturally 15->0.
  - count: ADDR_W+1 bits.
  - fetch_pend: 1 bit, a read was issued last cycle.
  - out_valid: 1 bit.
  - out_data: DATA_W bits.
  - prio: 0 = write first, 1 = read first.
- Reset (async, rst_n=0): all state zero, prio=0, so rd_valid=0, rd_data=0, full=0, level=0, ram_cs=0, ram_we=0.
  - Mid-operation reset discards RAM contents logically and drops any pending fetch.
  - No stale word may appear on rd_valid after reset release.
- Requests (combinational):
  - wr_req = wr_valid & (count < DEPTH).
  - rd_req = (count != 0) & ~fetch_pend & (~out_valid | rd_ready).
- Grant:
  - Only one request active: that request wins.
  - Both active: the side selected by prio wins, and prio toggles on that edge.
  - prio changes only on contention.
- wr_ready = (count < DEPTH) & (~rd_req | prio==0). It must not depend on wr_valid.
- RAM port (combinational from grant):
  - ram_cs = gnt_wr | gnt_rd.
  - ram_we = gnt_wr.
  - ram_addr = gnt_wr ? wr_ptr : rd_ptr.
  - ram_din = wr_data.
  - When idle: ram_cs=0, ram_we=0.
- On gnt_wr: wr_ptr+1, count+1.
- On gnt_rd: rd_ptr+1, count-1, fetch_pend<=1.
- gnt_wr and gnt_rd are never both set; count never over- or underflows.
- Cycle after gnt_rd (fetch_pend=1): out_data<=ram_dout, out_valid<=1, fetch_pend<=0 at end of that cycle.
- Pop: rd_valid & rd_ready clears out_valid unless a fill occurs on the same edge; fill has precedence.
- rd_req guarantees the output register is free when fetched data lands. No overwrite of an unpopped word is possible.
- Latency: a read granted in cycle N gives rd_valid=1 in cycle N+2. Write-to-RAM is 1 edge.
- Throughput: writes 1/cycle without contention. Reads at most 1 per 2 cycles (fetch_pend blocks back-to-back fetches).
- Total capacity is DEPTH + 1 (RAM plus output register).
- full = (count == DEPTH); level = count.

Test Plan:
- Reset, then wr_valid=1 with 0xAA (cycle 1) and 0xBB (cycle 2), rd_ready=0:
  - cycle 1: ram write addr 0.
  - cycle 2: contention, write wins, addr 1, prio->1.
  - cycle 3: read addr 0.
  - cycle 5: rd_valid=1, rd_data=0xAA.
  - level=1 after the fetch.
- rd_ready=0, push 0x00..0x13: exactly 17 words accepted. wr_ready=0 and full=1 once level=16. Pushes 0x11..0x13 stall with no ram_we.
- Push then pop 20 words 0x00..0x13 with rd_ready=1: output order is 0x00..0x13 exactly. wr_ptr/rd_ptr wrap 15->0 with no loss.
- Continuous wr_valid=1 with occupancy>0 and rd_ready=1: grants alternate write/read on contended cycles, with prio toggling each time.
- Pulse rst_n=0 asynchronously (mid-cycle) while fetch_pend=1 and out_valid=1:
  - rd_valid=0 and level=0 immediately.
  - After release, no data appears until a new write.
- Empty FIFO, rd_ready=1, wr_valid=0 for 10 cycles: ram_cs stays 0, rd_valid stays 0, level=0.
